hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline interlock controller for the five-stage core. Sits beside the ID stage and sequences it: it decodes the instruction currently in ID and tracks in-flight destination registers in a 3-entry scoreboard (EX/MEM/WB). From these it drives the operand forward selects, load-use stalls, ID/EX bubbles, and the post-redirect squash window that gates REGWR/MEMWR in ID.

## Interface
- SQUASH_DEPTH, 3: cycles `squash` stays high after a redirect (instructions fetched on the wrong path).
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_instr  in  32  instruction word currently latched in IF/ID.
- id_valid  in  1  IF/ID holds a real instruction.
- redirect  in  1  one-cycle pulse: taken branch, j/jal or jr resolved; PC is being reloaded this cycle.
- pc_hold  out  1  hold PC and IF/ID this cycle.
- idex_bubble  out  1  load all-zero controls into ID/EX this cycle.
- squash  out  1  ID must force REGWR=0 and MEMWR=0 on its output.
- fwd_a  out  2  rs operand source: 0 regfile, 1 EX result, 2 MEM result, 3 WB data.
- fwd_b  out  2  rt operand source, same encoding.
- stall_cnt  out  16  count of load-use stall cycles, saturating.

## Operation
- Decode (combinational from id_instr): op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], func=[5:0].
  - R (op=0): reads rs,rt; writes rd. func=0 (nop) reads and writes nothing. func=001011 (jr) reads rs only, writes nothing.
  - lw 001110: reads rs, writes rt, is_load=1.
  - sw 001111: reads rs,rt, no write.
  - beq 001000 / bne 001001: read rs,rt, no write.
  - Other op[5]=0: reads rs, writes rt.
  - j 100000: no reads/writes. jal 100001: writes 31. Other op[5]=1: treated as nop.
- Register 0 is never a source or destination for hazard purposes.
- Scoreboard: entries EX, MEM, WB, each {valid, dest[4:0], is_load}.
  - Every cycle: WB<=MEM, MEM<=EX.
  - EX<=decoded ID instruction, or invalid when idex_bubble, squash or !id_valid.
- Forwarding: per source, pick the youngest matching valid entry, priority EX>MEM>WB; regfile if no match.
  - EX match with is_load=1 cannot forward and forces a stall.
- States:
  - RUN: normal. Load-use hazard → pc_hold=1, idex_bubble=1, go to STALL.
  - STALL: one cycle. Return to RUN and re-evaluate; the load is now in MEM and forwards with fwd=2.
  - SQUASH: entered on redirect from any state; counter loaded with SQUASH_DEPTH. Decrement each cycle, return to RUN at 0. No stalls are raised while in SQUASH.
- Priority: redirect > load-use stall. A redirect during STALL abandons the stall.
- stall_cnt increments on each cycle with pc_hold=1 and saturates at 0xFFFF.

## Timing
- Reset (asynchronous) clears: state=RUN, scoreboard invalid, counter=0, pc_hold=0, idex_bubble=0, squash=0, fwd_a=fwd_b=0, stall_cnt=0.
- pc_hold, idex_bubble, fwd_a, fwd_b are combinational from the ID decode and current scoreboard. They are valid in the same cycle and never depend on `redirect`.
- squash is registered: high from the cycle after redirect for exactly SQUASH_DEPTH cycles.
  - A redirect arriving while squash is high reloads the counter, extending the window.
- Load-use latency: exactly 1 bubble cycle with forwarding.
- Reset asserted mid-STALL or mid-SQUASH returns to the reset values immediately. The first edge after deassertion behaves as RUN.

## Configuration
- HAZ_FORWARD_EN defined: forwarding as above; only load-use stalls.
- HAZ_FORWARD_EN undefined:
  - fwd_a and fwd_b are tied to 0.
  - Any ID source matching any valid scoreboard entry holds pc_hold=idex_bubble=1 until the entry leaves WB, giving up to 3 stall cycles.
  - STALL repeats while a match persists; each held cycle counts in stall_cnt.

## Test plan
- Reset mid-squash: assert rst during SQUASH → all outputs 0 immediately; next instruction decodes normally.
- Forwarding: add $3 followed by add $5,$3,$4 → fwd_a=1 in the second instruction's ID cycle, no stall. With one independent instruction between them → fwd_a=2.
- Load-use: lw $2 then sub $6,$2,$7 → exactly one cycle with pc_hold=idex_bubble=1, then fwd_a=2, stall_cnt=1.
- Register 0: lw $0 then add $1,$0,$0 → no stall, fwd_a=fwd_b=0.
- Redirect: pulse redirect → squash high for 3 cycles starting next cycle. A second pulse in squash cycle 2 → squash stays high 3 more cycles; squashed slots enter the scoreboard invalid.
- HAZ_FORWARD_EN undefined: add $3 then add $5,$3,$4 → 3 stall cycles, fwd outputs 0, stall_cnt=3.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Handshake bundle between the ID stage and the pipeline interlock controller.
// The master drives the ID-stage view; the slave returns stall, forward and squash controls.
interface hazard_ctrl_if;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        redirect;
    logic        pc_hold;
    logic        idex_bubble;
    logic        squash;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [15:0] stall_cnt;

    modport master (
        output id_instr, id_valid, redirect,
        input  pc_hold, idex_bubble, squash, fwd_a, fwd_b, stall_cnt
    );

    modport slave (
        input  id_instr, id_valid, redirect,
        output pc_hold, idex_bubble, squash, fwd_a, fwd_b, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Interlock controller for the five-stage core: EX/MEM/WB scoreboard, forwarding, stalls, squash.
// Define HAZ_FORWARD_EN for operand forwarding; otherwise any RAW match stalls until WB retires.
module hazard_ctrl #(
    parameter int unsigned SQUASH_DEPTH = 3
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave hif
);
    localparam int unsigned CntW = (SQUASH_DEPTH > 1) ? $clog2(SQUASH_DEPTH) : 1;
    localparam logic [CntW-1:0] SqLoad = CntW'(SQUASH_DEPTH - 1);

    localparam logic [1:0] StRun    = 2'd0;
    localparam logic [1:0] StStall  = 2'd1;
    localparam logic [1:0] StSquash = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] sq_cnt_q, sq_cnt_d;
    logic [15:0]     stall_cnt_q;

    logic            ex_v_q, mem_v_q, wb_v_q;
    logic [4:0]      ex_dst_q, mem_dst_q, wb_dst_q;

    logic [5:0] op, func;
    logic [4:0] rs, rt, rd;
    logic       use_rs, use_rt, wr_en;
    logic [4:0] wr_dst;

    assign op   = hif.id_instr[31:26];
    assign rs   = hif.id_instr[25:21];
    assign rt   = hif.id_instr[20:16];
    assign rd   = hif.id_instr[15:11];
    assign func = hif.id_instr[5:0];

    always_comb begin
        use_rs = 1'b0;
        use_rt = 1'b0;
        wr_en  = 1'b0;
        wr_dst = rt;
        if (op == 6'd0) begin
            if (func == 6'b001011) begin
                use_rs = 1'b1;
            end else if (func != 6'd0) begin
                use_rs = 1'b1;
                use_rt = 1'b1;
                wr_en  = 1'b1;
                wr_dst = rd;
            end
        end else if (!op[5]) begin
            use_rs = 1'b1;
            case (op)
                6'b001111, 6'b001000, 6'b001001: use_rt = 1'b1;
                default:                         wr_en  = 1'b1;
            endcase
        end else if (op == 6'b100001) begin
            wr_en  = 1'b1;
            wr_dst = 5'd31;
        end
    end

    // Register 0 never creates a dependency.
    logic src_a, src_b;
    assign src_a = hif.id_valid && use_rs && (rs != 5'd0);
    assign src_b = hif.id_valid && use_rt && (rt != 5'd0);

    logic a_ex, a_mem, a_wb, b_ex, b_mem, b_wb;
    assign a_ex  = src_a && ex_v_q  && (ex_dst_q  == rs);
    assign a_mem = src_a && mem_v_q && (mem_dst_q == rs);
    assign a_wb  = src_a && wb_v_q  && (wb_dst_q  == rs);
    assign b_ex  = src_b && ex_v_q  && (ex_dst_q  == rt);
    assign b_mem = src_b && mem_v_q && (mem_dst_q == rt);
    assign b_wb  = src_b && wb_v_q  && (wb_dst_q  == rt);

    logic       hazard_raw, hazard, in_squash;
    logic [1:0] fwd_a, fwd_b;

`ifdef HAZ_FORWARD_EN
    logic ex_ld_q;

    always_comb begin
        hazard_raw = (a_ex || b_ex) && ex_ld_q;
        fwd_a = a_ex ? (ex_ld_q ? 2'd0 : 2'd1) : a_mem ? 2'd2 : a_wb ? 2'd3 : 2'd0;
        fwd_b = b_ex ? (ex_ld_q ? 2'd0 : 2'd1) : b_mem ? 2'd2 : b_wb ? 2'd3 : 2'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ex_ld_q <= 1'b0;
        else     ex_ld_q <= (op == 6'b001110);
    end
`else
    always_comb begin
        hazard_raw = a_ex || a_mem || a_wb || b_ex || b_mem || b_wb;
        fwd_a      = 2'd0;
        fwd_b      = 2'd0;
    end
`endif

    assign in_squash = (state_q == StSquash);
    assign hazard    = hazard_raw && !in_squash;

    always_comb begin
        state_d  = state_q;
        sq_cnt_d = sq_cnt_q;
        if (hif.redirect) begin
            state_d  = StSquash;
            sq_cnt_d = SqLoad;
        end else begin
            case (state_q)
                StSquash: begin
                    if (sq_cnt_q == '0) state_d = StRun;
                    else                sq_cnt_d = sq_cnt_q - 1'b1;
                end
                default: state_d = hazard ? StStall : StRun;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            sq_cnt_q    <= '0;
            stall_cnt_q <= '0;
            ex_v_q      <= 1'b0;
            mem_v_q     <= 1'b0;
            wb_v_q      <= 1'b0;
            ex_dst_q    <= '0;
            mem_dst_q   <= '0;
            wb_dst_q    <= '0;
        end else begin
            state_q   <= state_d;
            sq_cnt_q  <= sq_cnt_d;
            if (hazard && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
            ex_v_q    <= hif.id_valid && wr_en && (wr_dst != 5'd0) && !hazard && !in_squash;
            ex_dst_q  <= wr_dst;
            mem_v_q   <= ex_v_q;
            mem_dst_q <= ex_dst_q;
            wb_v_q    <= mem_v_q;
            wb_dst_q  <= mem_dst_q;
        end
    end

    assign hif.pc_hold     = hazard;
    assign hif.idex_bubble = hazard;
    assign hif.squash      = in_squash;
    assign hif.fwd_a       = fwd_a;
    assign hif.fwd_b       = fwd_b;
    assign hif.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; expectations follow the HAZ_FORWARD_EN setting of the build.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_if hif ();

    hazard_ctrl #(.SQUASH_DEPTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

`ifdef HAZ_FORWARD_EN
    localparam bit Fwd = 1'b1;
`else
    localparam bit Fwd = 1'b0;
`endif

    int unsigned n_tests;
    int unsigned n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt);
        return {op, rs, rt, 16'd0};
    endfunction

    // Drive one ID cycle just after the edge; outputs settle before the sample point.
    task automatic cyc(input logic [31:0] ins, input logic redir);
        @(posedge clk);
        #1;
        hif.id_instr = ins;
        hif.id_valid = 1'b1;
        hif.redirect = redir;
        #2;
    endtask

    task automatic flush();
        repeat (3) cyc(32'd0, 1'b0);
    endtask

    logic [31:0] nop, add3, add53, add8, lw2, sub627, lw0, add100;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        nop     = 32'd0;
        add3    = rtype(5'd1, 5'd2, 5'd3, 6'h20);
        add53   = rtype(5'd3, 5'd4, 5'd5, 6'h20);
        add8    = rtype(5'd9, 5'd10, 5'd8, 6'h20);
        lw2     = itype(6'b001110, 5'd1, 5'd2);
        sub627  = rtype(5'd2, 5'd7, 5'd6, 6'h22);
        lw0     = itype(6'b001110, 5'd1, 5'd0);
        add100  = rtype(5'd0, 5'd0, 5'd1, 6'h20);

        rst = 1'b0;
        hif.id_instr = 32'd0;
        hif.id_valid = 1'b0;
        hif.redirect = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_pc_hold", hif.pc_hold, 0);
        check("rst_bubble", hif.idex_bubble, 0);
        check("rst_squash", hif.squash, 0);
        check("rst_fwd_a", hif.fwd_a, 0);
        check("rst_fwd_b", hif.fwd_b, 0);
        check("rst_stall_cnt", hif.stall_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Back-to-back dependency on $3
        cyc(add3, 1'b0);
        check("a_first_hold", hif.pc_hold, 0);
`ifndef HAZ_FORWARD_EN
        for (int i = 0; i < 3; i++) begin
            cyc(add53, 1'b0);
            check("a_stall_hold", hif.pc_hold, 1);
            check("a_stall_bubble", hif.idex_bubble, 1);
            check("a_stall_fwd_a", hif.fwd_a, 0);
        end
`endif
        cyc(add53, 1'b0);
        check("a_issue_hold", hif.pc_hold, 0);
        check("a_fwd_a", hif.fwd_a, Fwd ? 1 : 0);
        check("a_fwd_b", hif.fwd_b, 0);
        check("a_stall_cnt", hif.stall_cnt, Fwd ? 0 : 3);
        flush();

        // One independent instruction in between
        cyc(add3, 1'b0);
        cyc(add8, 1'b0);
        check("b_mid_hold", hif.pc_hold, 0);
`ifndef HAZ_FORWARD_EN
        for (int i = 0; i < 2; i++) begin
            cyc(add53, 1'b0);
            check("b_stall_hold", hif.pc_hold, 1);
        end
`endif
        cyc(add53, 1'b0);
        check("b_issue_hold", hif.pc_hold, 0);
        check("b_fwd_a", hif.fwd_a, Fwd ? 2 : 0);
        check("b_stall_cnt", hif.stall_cnt, Fwd ? 0 : 5);
        flush();

        // Load-use
        cyc(lw2, 1'b0);
        cyc(sub627, 1'b0);
        check("c_lu_hold", hif.pc_hold, 1);
        check("c_lu_bubble", hif.idex_bubble, 1);
`ifndef HAZ_FORWARD_EN
        for (int i = 0; i < 2; i++) begin
            cyc(sub627, 1'b0);
            check("c_stall_hold", hif.pc_hold, 1);
        end
`endif
        cyc(sub627, 1'b0);
        check("c_issue_hold", hif.pc_hold, 0);
        check("c_issue_bubble", hif.idex_bubble, 0);
        check("c_fwd_a", hif.fwd_a, Fwd ? 2 : 0);
        check("c_fwd_b", hif.fwd_b, 0);
        check("c_stall_cnt", hif.stall_cnt, Fwd ? 1 : 8);
        flush();

        // Register 0 is never a dependency
        cyc(lw0, 1'b0);
        cyc(add100, 1'b0);
        check("d_r0_hold", hif.pc_hold, 0);
        check("d_r0_fwd_a", hif.fwd_a, 0);
        check("d_r0_fwd_b", hif.fwd_b, 0);
        check("d_stall_cnt", hif.stall_cnt, Fwd ? 1 : 8);

        // Single redirect: three squash cycles
        cyc(nop, 1'b1);
        check("e_redir_cycle_squash", hif.squash, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(nop, 1'b0);
            check("e_squash_high", hif.squash, 1);
        end
        cyc(nop, 1'b0);
        check("e_squash_done", hif.squash, 0);

        // Second redirect in squash cycle 2 extends the window
        cyc(nop, 1'b1);
        check("e2_redir_cycle_squash", hif.squash, 0);
        cyc(nop, 1'b0);
        check("e2_c1_squash", hif.squash, 1);
        cyc(nop, 1'b1);
        check("e2_c2_squash", hif.squash, 1);
        for (int i = 0; i < 2; i++) begin
            cyc(nop, 1'b0);
            check("e2_ext_squash", hif.squash, 1);
        end
        cyc(add3, 1'b0);
        check("e2_last_squash", hif.squash, 1);
        cyc(add53, 1'b0);
        check("e2_done_squash", hif.squash, 0);
        check("e2_squashed_no_hold", hif.pc_hold, 0);
        check("e2_squashed_no_fwd", hif.fwd_a, 0);
        flush();

        // Reset asserted mid-squash
        cyc(nop, 1'b1);
        cyc(nop, 1'b0);
        check("f_pre_squash", hif.squash, 1);
        @(posedge clk);
        #1;
        hif.redirect = 1'b0;
        rst = 1'b1;
        #1;
        check("f_rst_squash", hif.squash, 0);
        check("f_rst_hold", hif.pc_hold, 0);
        check("f_rst_stall_cnt", hif.stall_cnt, 0);
        check("f_rst_fwd_a", hif.fwd_a, 0);
        #1 rst = 1'b0;
        cyc(add3, 1'b0);
        check("f_after_squash", hif.squash, 0);
        check("f_after_hold", hif.pc_hold, 0);
        cyc(add53, 1'b0);
        check("f_dep_hold", hif.pc_hold, Fwd ? 0 : 1);
        check("f_dep_fwd_a", hif.fwd_a, Fwd ? 1 : 0);
        flush();

        // Redirect during a load-use stall wins; squash suppresses further stalls
        cyc(lw2, 1'b0);
        cyc(sub627, 1'b0);
        check("g_lu_hold", hif.pc_hold, 1);
        cyc(sub627, 1'b1);
        check("g_redir_hold", hif.pc_hold, Fwd ? 0 : 1);
        cyc(sub627, 1'b0);
        check("g_squash", hif.squash, 1);
        check("g_squash_no_hold", hif.pc_hold, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
